// File: rtl/muldiv_seq_if.sv
// Request/result bus between the EX-stage control and the HI/LO multiply/divide sequencer.
interface muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Bit-serial MULT/MULTU/DIV/DIVU sequencer owning HI/LO (shift-add multiply, restoring divide).
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the remaining multiplier bits are zero.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic         clk,
    input logic         rst_n,
    muldiv_seq_if.slave bus
);
    localparam int unsigned W2 = 2 * WIDTH;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EarlyOut = 1'b1;
`else
    localparam bit EarlyOut = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;     // product, or {partial remainder, dividend/quotient}
    logic [W2-1:0]    mcand_q, mcand_d; // multiplicand aligned to the current bit weight
    logic [WIDTH-1:0] opb_q, opb_d;     // multiplier consumed LSB first, or divisor
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             accept;
    logic             last;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [W2-1:0]    step;
    logic [WIDTH:0]   trial;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        step      = acc_q;
        trial     = '0;
        last      = 1'b0;

        accept = bus.start && (state_q == StIdle || state_q == StDone);
        mag_a  = (bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b  = (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;

        unique case (state_q)
            StMul: begin
                step    = opb_q[0] ? acc_q + mcand_q : acc_q;
                acc_d   = step;
                mcand_d = mcand_q << 1;
                opb_d   = opb_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                last    = (cnt_q == CNT_W'(WIDTH - 1)) || (EarlyOut && opb_q[WIDTH-1:1] == '0);
                if (last) begin
                    {hi_d, lo_d} = neg_q ? -step : step;
                    state_d      = StDone;
                end
            end
            StDiv: begin
                // Partial remainder is WIDTH+1 bits wide before the trial subtract.
                trial = acc_q[W2-1:WIDTH-1] - {1'b0, opb_q};
                if (!trial[WIDTH]) step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else               step = {acc_q[W2-2:0], 1'b0};
                acc_d = step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    lo_d    = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
                    hi_d    = neg_rem_q ? -step[W2-1:WIDTH] : step[W2-1:WIDTH];
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (accept) begin
            cnt_d     = '0;
            dbz_d     = 1'b0;
            opb_d     = mag_b;
            neg_d     = bus.op[0] && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem_d = bus.op[0] && bus.a[WIDTH-1];
            if (bus.op[1]) begin
                acc_d = {{WIDTH{1'b0}}, mag_a};
                if (bus.b == '0) begin
                    hi_d    = bus.a;
                    lo_d    = '1;
                    dbz_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StDiv;
                end
            end else begin
                acc_d   = '0;
                mcand_d = {{WIDTH{1'b0}}, mag_a};
                state_d = StMul;
            end
        end else if (state_q == StIdle || state_q == StDone) begin
            if (bus.wr_hi) hi_d = bus.wdata;
            if (bus.wr_lo) lo_d = bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy        = (state_q == StMul) || (state_q == StDiv);
    assign bus.done        = (state_q == StDone);
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: results are queued at issue and checked on each done pulse.
module tb_muldiv_seq;
    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(WIDTH)) bus ();

    muldiv_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Expected multiply latency (cycles from accept edge to done).
    function automatic int mul_lat(input logic [31:0] mb);
        int h;
        h = 0;
        for (int i = 0; i < 32; i++) if (mb[i]) h = i;
`ifdef MULDIV_EARLY_OUT_EN
        return h + 2;
`else
        return WIDTH + 1;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done", 64'(bus.done), 64'(0));
            end else begin
                mon_e = sb_q.pop_front();
                chk("hi", 64'(bus.hi), 64'(mon_e.hi));
                chk("lo", 64'(bus.lo), 64'(mon_e.lo));
                chk("div_by_zero", 64'(bus.div_by_zero), 64'(mon_e.dbz));
            end
        end
    end

    // Called at a falling edge; returns at the falling edge of cycle 1 after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                         input bit push);
        if (push) sb_q.push_back('{ehi, elo, edbz});
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int elat, input int n0);
        int n;
        int nbusy;
        n     = n0;
        nbusy = 0;
        while (!bus.done && n < 200) begin
            if (bus.busy) nbusy++;
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'(elat));
        chk({nm, "_busy_cycles"}, 64'(nbusy), 64'(elat - n0));
    endtask

    initial begin
        int seen;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.a     = '0;
        bus.b     = '0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_dbz", 64'(bus.div_by_zero), 64'(0));
        chk("rst_hi", 64'(bus.hi), 64'(0));
        chk("rst_lo", 64'(bus.lo), 64'(0));

        // Start and MTHI while busy must both be ignored.
        issue(2'd0, 32'h10, 32'h0001_0000, 32'h0, 32'h0010_0000, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd1; bus.b = 32'd1;
        bus.wr_hi = 1'b1; bus.wdata = 32'h1234;
        @(negedge clk);
        bus.start = 1'b0; bus.wr_hi = 1'b0;
        wait_done("busy_ignore", mul_lat(32'h0001_0000), 4);
        @(negedge clk);
        chk("busy_ignore_idle", 64'(bus.busy), 64'(0));

        issue(2'd0, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, 1'b0, 1'b1);
        wait_done("multu", mul_lat(32'd2), 1);
        @(negedge clk);

        bus.wr_lo = 1'b1; bus.wdata = 32'hABCD;
        @(negedge clk);
        bus.wr_lo = 1'b0;
        chk("mtlo_lo", 64'(bus.lo), 64'(32'hABCD));
        chk("mtlo_hi_kept", 64'(bus.hi), 64'(32'h1));

        issue(2'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
        wait_done("mult", mul_lat(32'd7), 1);
        @(negedge clk);

        issue(2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 1'b1);
        wait_done("mult_minmin", mul_lat(32'h8000_0000), 1);
        @(negedge clk);

        // DIV followed back-to-back by DIVU started during DONE.
        issue(2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
        wait_done("div", WIDTH + 1, 1);
        issue(2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
        wait_done("divu_b2b", WIDTH + 1, 1);
        @(negedge clk);

        issue(2'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b1);
        wait_done("div_zero", 1, 1);
        @(negedge clk);
        chk("dbz_held", 64'(bus.div_by_zero), 64'(1));
        issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b1);
        chk("dbz_cleared", 64'(bus.div_by_zero), 64'(0));
        wait_done("div_ovf", WIDTH + 1, 1);
        @(negedge clk);

        issue(2'd0, 32'd9, 32'd1, 32'h0, 32'd9, 1'b0, 1'b1);
        wait_done("multu_b1", mul_lat(32'd1), 1);
        @(negedge clk);

        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'h5555;
        @(negedge clk);
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        chk("mthi_both", 64'(bus.hi), 64'(32'h5555));
        chk("mtlo_both", 64'(bus.lo), 64'(32'h5555));

        // Reset during iteration 10 of a MULT: no done may follow.
        issue(2'd1, 32'd3, 32'hC000_0000, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_done", 64'(bus.done), 64'(0));
        chk("abort_hi", 64'(bus.hi), 64'(0));
        chk("abort_lo", 64'(bus.lo), 64'(0));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'(0));
        chk("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
